// File: rtl/pool_stream.sv
`default_nettype none
// ============================================================================
// Module      : pool_stream
// Description : Streaming 2-D pooling over a square feature map delivered in
//               raster order. Each POOLxPOOL window (stride POOL) is reduced
//               to its signed maximum (mode 0) or to its floored average
//               (mode 1). Mode is captured with the first pixel of a frame.
// Revision    : 1.0 - initial release
//
// Ports
//   clk        : clock, all state updates on the rising edge
//   rst        : synchronous reset, active low
//   in_valid   : in_data is accepted this cycle
//   in_data    : signed input pixel, row-major, column 0 first
//   mode       : 0 = max pool, 1 = average pool (sampled at pixel (0,0))
//   out_valid  : one-cycle pulse per pooled result
//   out_data   : pooled result, held between pulses
//   out_row    : output-map row of out_data
//   out_col    : output-map column of out_data
//   frame_done : pulses with the last result of a frame
// ============================================================================
module pool_stream #(
  parameter int BIT_WIDTH = 32,
  parameter int MAP_SIZE  = 28,
  parameter int POOL      = 2,
  localparam int CW = ((MAP_SIZE / POOL) > 1) ? $clog2(MAP_SIZE / POOL) : 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  input  logic signed [BIT_WIDTH-1:0] in_data,
  input  logic                        mode,
  output logic                        out_valid,
  output logic signed [BIT_WIDTH-1:0] out_data,
  output logic [CW-1:0]               out_row,
  output logic [CW-1:0]               out_col,
  output logic                        frame_done
);

  localparam int LP   = (POOL == 4) ? 2 : 1;           // log2(POOL)
  localparam int SW   = BIT_WIDTH + 2 * LP;            // overflow-free sum width
  localparam int NCOL = MAP_SIZE / POOL;
  localparam int IW   = (MAP_SIZE > 1) ? $clog2(MAP_SIZE) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(MAP_SIZE - 1);
  localparam logic [LP-1:0] LAST_PH  = LP'(POOL - 1);

  logic [IW-1:0]        r_col;
  logic [IW-1:0]        r_row;
  logic                 r_mode;
  logic signed [SW-1:0] r_hacc;
  logic signed [SW-1:0] r_cbuf [NCOL];

  logic                 w_first;
  logic                 w_mode;
  logic [LP-1:0]        w_cph;
  logic [LP-1:0]        w_rph;
  logic [CW-1:0]        w_bidx;
  logic signed [SW-1:0] w_pix;
  logic signed [SW-1:0] w_hacc;
  logic signed [SW-1:0] w_cbuf_rd;
  logic signed [SW-1:0] w_vacc;

  always_comb begin
    w_first   = (r_row == '0) && (r_col == '0);
    // The pixel at (0,0) uses the live mode input since the latch only
    // captures it at that same edge.
    w_mode    = w_first ? mode : r_mode;
    w_cph     = r_col[LP-1:0];
    w_rph     = r_row[LP-1:0];
    w_bidx    = CW'(r_col >> LP);
    w_pix     = {{(2 * LP){in_data[BIT_WIDTH-1]}}, in_data};
    w_cbuf_rd = r_cbuf[w_bidx];

    // Horizontal reduction across one row of the window.
    w_hacc = w_pix;
    if (w_cph != '0) begin
      if (w_mode)
        w_hacc = r_hacc + w_pix;
      else
        w_hacc = (w_pix > r_hacc) ? w_pix : r_hacc;
    end

    // Vertical reduction of the row partials held in the column buffer.
    w_vacc = w_hacc;
    if (w_rph != '0) begin
      if (w_mode)
        w_vacc = w_cbuf_rd + w_hacc;
      else
        w_vacc = (w_hacc > w_cbuf_rd) ? w_hacc : w_cbuf_rd;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_col      <= '0;
      r_row      <= '0;
      r_mode     <= 1'b0;
      r_hacc     <= '0;
      for (int i = 0; i < NCOL; i++)
        r_cbuf[i] <= '0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_row    <= '0;
      out_col    <= '0;
      frame_done <= 1'b0;
    end else begin
      out_valid  <= 1'b0;
      frame_done <= 1'b0;
      if (in_valid) begin
        if (r_col == LAST_IDX) begin
          r_col <= '0;
          r_row <= (r_row == LAST_IDX) ? '0 : r_row + IW'(1);
        end else begin
          r_col <= r_col + IW'(1);
        end

        if (w_first)
          r_mode <= mode;

        r_hacc <= w_hacc;

        if (w_cph == LAST_PH)
          r_cbuf[w_bidx] <= w_vacc;

        if ((w_cph == LAST_PH) && (w_rph == LAST_PH)) begin
          out_valid <= 1'b1;
          // Selecting the upper slice is the arithmetic right shift by
          // 2*log2(POOL) followed by truncation to BIT_WIDTH.
          out_data   <= w_mode ? w_vacc[2*LP +: BIT_WIDTH] : w_vacc[BIT_WIDTH-1:0];
          out_row    <= CW'(r_row >> LP);
          out_col    <= w_bidx;
          frame_done <= (r_row == LAST_IDX) && (r_col == LAST_IDX);
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: doc/pool_stream.md
POOL_STREAM -- requirements
Module: pool_stream

Interface
REQ-001 Parameter BIT_WIDTH, default 32, signed width of input pixels and pooled output.
REQ-002 Parameter MAP_SIZE, default 28, input feature-map width and height in pixels (square map).
REQ-003 Parameter POOL, default 2, pooling window edge and stride; legal values 2 or 4; MAP_SIZE SHALL be a multiple of POOL.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  reset; synchronous, active-low.
REQ-006 in_valid  input  1  high = in_data accepted this cycle.
REQ-007 in_data  input  BIT_WIDTH signed  pixel, raster order (row-major, column 0 first).
REQ-008 mode  input  1  0 = max pool, 1 = average pool; sampled only with a frame's first pixel.
REQ-009 out_valid  output  1  one-cycle pulse per pooled result.
REQ-010 out_data  output  BIT_WIDTH signed  pooled result; held between pulses.
REQ-011 out_row, out_col  output  max(1,clog2(MAP_SIZE/POOL)) each  output-map coordinates of out_data.
REQ-012 frame_done  output  1  pulse coincident with the last out_valid of a frame.

Function
REQ-013 Block SHALL keep input column counter (0..MAP_SIZE-1) and row counter (0..MAP_SIZE-1), advancing only on in_valid; column wraps to 0 and increments row; row wraps to 0 after the last pixel, starting a new frame.
REQ-014 in_valid low SHALL freeze all counters, accumulators and the column buffer; gaps of any length SHALL not alter results.
REQ-015 mode SHALL be latched when the pixel at (row 0, col 0) is accepted; mode changes at any other time SHALL be ignored until the next frame.
REQ-016 A horizontal accumulator SHALL combine POOL consecutive pixels of a row: running max (mode 0) or running sum (mode 1), reloaded from the pixel at column phase 0.
REQ-017 A column buffer of MAP_SIZE/POOL entries SHALL hold per-output-column partial results across the POOL rows of a window band; entry loaded at row phase 0, combined at later row phases.
REQ-018 Sums SHALL use BIT_WIDTH+2*log2(POOL) bits internally with no overflow.
REQ-019 Average result SHALL be the full window sum arithmetically shifted right by 2*log2(POOL) (floor toward negative infinity), then truncated to BIT_WIDTH.
REQ-020 Max comparison SHALL be signed; ties give the equal value.
REQ-021 out_valid SHALL assert exactly one cycle after acceptance of the pixel at row phase POOL-1, column phase POOL-1, with out_data, out_row = row/POOL, out_col = col/POOL of that window.
REQ-022 Results SHALL be emitted in raster order of the output map, (MAP_SIZE/POOL)^2 per frame.
REQ-023 frame_done SHALL pulse with out_valid for output (MAP_SIZE/POOL-1, MAP_SIZE/POOL-1) only.
REQ-024 Back-to-back frames with continuous in_valid SHALL be supported with no bubble; next frame's first pixel may be accepted in the cycle its predecessor's final result is emitted.
REQ-025 No backpressure: consumer SHALL sample out_data whenever out_valid is high.

Reset
REQ-026 With rst low at a rising edge: counters, accumulators, column buffer, latched mode, out_data, out_row, out_col cleared to 0; out_valid and frame_done 0.
REQ-027 Reset mid-frame SHALL discard partial windows; first in_valid after release is pixel (0,0) of a new frame.
REQ-028 in_valid during reset SHALL be ignored.

Verification
REQ-029 MAP_SIZE=4, POOL=2, mode 0, pixels 0..15 raster, continuous -> out_data 5,7,13,15 at (0,0),(0,1),(1,0),(1,1); frame_done with 15.
REQ-030 Same map, mode 1, window pixels -1,-2,-5,-6 at (0,0) -> out_data -4 (-14>>>2 = -3.5 floored); window 2,3,6,7 -> 4 (18>>>2).
REQ-031 Mode 0, pixels 0..15 fed with in_valid toggling 1/0 and random gaps up to 5 cycles -> identical results to REQ-029, each one cycle after the triggering pixel.
REQ-032 Reset asserted after 6 pixels, then full 0..15 frame -> only the four REQ-029 outputs, no spurious pulse.
REQ-033 MAP_SIZE=8, POOL=4, mode 1, all pixels 0x7FFFFFFF -> four outputs 0x7FFFFFFF (no overflow); mode 0 all -1 -> four outputs -1.
REQ-034 Two back-to-back frames, mode toggled 0->1 mid frame 1 and held at 1 -> frame 1 max, frame 2 average, 8 out_valid pulses, 2 frame_done.
